// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues single-outstanding imem requests and buffers one instruction.
// Optional macro PC_MISALIGN_TRAP_EN redirects misaligned branch targets to TRAP_VECTOR.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc_plus_4,
    output logic [31:0] pc_target,
    output logic        PCSel,
    input  logic [31:0] pc_next,
    output logic        misalign_trap
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        kill_q, kill_d;
    logic        misaligned_s;

`ifdef PC_MISALIGN_TRAP_EN
    assign misaligned_s = (br_target[1:0] != 2'b00);
`else
    assign misaligned_s = 1'b0;
`endif

    assign pc_target  = misaligned_s ? TRAP_VECTOR : br_target;
    assign PCSel      = br_taken;
    assign pc_plus_4  = pc_q + 32'd4;
    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = pc_q;
    // A redirect in HOLD flushes the buffer, so decode must not see it as valid that cycle.
    assign inst_valid = (state_q == ST_HOLD) & ~br_taken;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    // Next-state, PC, kill and buffer logic.
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (br_taken) begin
            pc_d = pc_next;
        end else if ((state_q == ST_HOLD) && inst_ready) begin
            pc_d = pc_next;
        end else begin
            pc_d = pc_q;
        end
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                    // Granted with the old PC while redirecting: its response is stale.
                    kill_d  = br_taken;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    kill_d = 1'b0;
                    if (kill_q || br_taken) begin
                        state_d = ST_REQ;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = ST_HOLD;
                    end
                end else if (br_taken) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
            end
            ST_HOLD: begin
                if (br_taken || inst_ready) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VECTOR;
            kill_q    <= 1'b0;
            inst_q    <= 32'h0000_0000;
            inst_pc_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q, trap_d;

    // One-cycle trap pulse following a misaligned redirect.
    always_comb begin
        trap_d = br_taken & misaligned_s;
    end

    // Trap pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign misalign_trap = trap_q;
`else
    assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: memory model, expected fetch-stream scoreboard and a decoupled monitor.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, inst_ready, br_taken, PCSel, misalign_trap;
    logic [31:0] inst, inst_pc, br_target, pc_plus_4, pc_target, pc_next;

    int checks = 0;
    int errors = 0;
    int deliveries = 0;

    // Expected fetch stream: front entry is the PC of the next instruction decode should receive.
    logic [31:0] exp_q[$];
    logic        trap_pend = 1'b0;
    logic        trap_exp  = 1'b0;

    // Memory model state.
    bit          busy = 1'b0;
    int          dly = 0;
    logic [31:0] maddr = 32'h0;
    int          gnt_en = 1;
    int          delay_cfg = 0;
    bit          rand_mode = 1'b0;
    bit          gnt_issued = 1'b0;

    always #5 clk = ~clk;

    assign pc_next = PCSel ? pc_target : pc_plus_4;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .br_taken(br_taken), .br_target(br_target),
        .pc_plus_4(pc_plus_4), .pc_target(pc_target), .PCSel(PCSel),
        .pc_next(pc_next), .misalign_trap(misalign_trap)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic mis(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] map_tgt(input logic [31:0] t);
        return mis(t) ? 32'h0000_0010 : t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; br_taken = 1'b0; br_target = 32'h0; inst_ready = 1'b0;
            imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
            busy = 1'b0; trap_pend = 1'b0; trap_exp = 1'b0; gnt_issued = 1'b0;
            exp_q.delete();
            exp_q.push_back(RV);
            #4;
        end
    endtask

    // One cycle: inputs driven at the falling edge, returns 4 time units later (before the rising edge).
    task automatic step(input bit br, input logic [31:0] tgt, input bit rdy);
        bit resp_now;
        bit g;
        @(negedge clk);
        rst = 1'b0;
        resp_now = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        imem_gnt = 1'b0;
        gnt_issued = 1'b0;
        if (busy) begin
            if (dly == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_f(maddr);
                busy = 1'b0;
                resp_now = 1'b1;
            end else begin
                dly--;
            end
        end else if (rand_mode && ($urandom_range(0, 15) == 0)) begin
            imem_rvalid = 1'b1;
        end
        br_taken = br;
        br_target = tgt;
        inst_ready = rdy;
        g = (gnt_en == 1) || ((gnt_en == 2) && ($urandom_range(0, 3) != 0));
        if (!busy && !resp_now && imem_req && g) begin
            imem_gnt = 1'b1;
            maddr = imem_addr;
            busy = 1'b1;
            dly = (delay_cfg < 0) ? int'($urandom_range(0, 2)) : delay_cfg;
            gnt_issued = 1'b1;
        end
        trap_exp = trap_pend;
        trap_pend = br && mis(tgt);
        if (br) begin
            exp_q.delete();
            exp_q.push_back(map_tgt(tgt));
        end
        #4;
    endtask

    task automatic run_until(input int what, input bit rdy);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(1'b0, 32'h0, rdy);
            case (what)
                0: hit = imem_req;
                1: hit = inst_valid;
                2: hit = gnt_issued;
                default: hit = 1'b1;
            endcase
        end
        chk("wait_bound", {31'b0, hit}, 32'd1);
    endtask

    // Monitor: compares every decode handshake against the expected stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, trap_exp});
                if (br_taken) begin
                    chk("valid_in_redirect", {31'b0, inst_valid}, 32'd0);
                    chk("pc_target", pc_target, map_tgt(br_target));
                    chk("pcsel", {31'b0, PCSel}, 32'd1);
                end
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_inst", inst_pc, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_pc", inst_pc, e);
                        chk("inst", inst, mem_f(e));
                        exp_q.push_back(e + 32'd4);
                        deliveries++;
                    end
                end
            end
        end
    end

    initial begin
        int vidx[$];
        logic [31:0] addrs[$];
        logic [31:0] t6;
        br_taken = 1'b0; br_target = 32'h0; inst_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        do_reset(2);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RV);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_pcsel", {31'b0, PCSel}, 32'd0);
        chk("rst_trap", {31'b0, misalign_trap}, 32'd0);

        // Sequential fetch with a one-cycle memory.
        gnt_en = 1; delay_cfg = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (imem_req) addrs.push_back(imem_addr);
            if (inst_valid) vidx.push_back(k);
        end
        if (addrs.size() >= 3 && vidx.size() >= 2) begin
            chk("seq_addr0", addrs[0], 32'h0);
            chk("seq_addr1", addrs[1], 32'h4);
            chk("seq_addr2", addrs[2], 32'h8);
            chk("seq_valid0", 32'(vidx[0]), 32'd3);
            chk("seq_valid1", 32'(vidx[1]), 32'd6);
        end else begin
            chk("seq_count", 32'(addrs.size() * 16 + vidx.size()), 32'd50);
        end

        // Redirect while waiting; late response must be dropped.
        delay_cfg = 1;
        run_until(2, 1'b1);
        step(1'b1, 32'h100, 1'b1);
        chk("wait_br_req", {31'b0, imem_req}, 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("wait_drop_valid", {31'b0, inst_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("wait_br_addr", imem_addr, 32'h100);
        run_until(1, 1'b1);
        chk("wait_br_inst_pc", inst_pc, 32'h100);

        // Redirect while holding beats a simultaneous ready.
        delay_cfg = 0;
        run_until(1, 1'b0);
        step(1'b1, 32'h200, 1'b1);
        chk("hold_br_valid", {31'b0, inst_valid}, 32'd0);
        run_until(0, 1'b1);
        chk("hold_br_addr", imem_addr, 32'h200);

        // Grant and redirect in the same cycle.
        gnt_en = 0;
        run_until(0, 1'b1);
        gnt_en = 1;
        step(1'b1, 32'h40, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("req_br_valid", {31'b0, inst_valid}, 32'd0);
        chk("req_br_req", {31'b0, imem_req}, 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("req_br_reqn", {31'b0, imem_req}, 32'd1);
        chk("req_br_addr", imem_addr, 32'h40);

        // PC wrap and a stalled decode.
        step(1'b1, 32'hFFFF_FFFC, 1'b0);
        run_until(1, 1'b0);
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus_4, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_inst", inst, mem_f(32'hFFFF_FFFC));
            chk("stall_inst_pc", inst_pc, 32'hFFFF_FFFC);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        step(1'b0, 32'h0, 1'b1);
        run_until(0, 1'b1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Misaligned redirect.
        t6 = map_tgt(32'h102);
        run_until(1, 1'b0);
        step(1'b1, 32'h102, 1'b0);
        chk("mis_target", pc_target, t6);
        step(1'b0, 32'h0, 1'b0);
        chk("mis_trap", {31'b0, misalign_trap}, {31'b0, mis(32'h102)});
        chk("mis_addr", imem_addr, t6);
        step(1'b0, 32'h0, 1'b0);
        chk("mis_trap_end", {31'b0, misalign_trap}, 32'd0);

        // Randomized traffic with one mid-run reset.
        rand_mode = 1'b1; gnt_en = 2; delay_cfg = -1;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            bit br;
            if (n == 1500) begin
                do_reset(2);
                chk("midrst_req", {31'b0, imem_req}, 32'd0);
                chk("midrst_valid", {31'b0, inst_valid}, 32'd0);
            end
            br = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: tgt = $urandom & 32'hFFFF_FFFC;
                1: tgt = $urandom;
                2: tgt = 32'hFFFF_FFFC;
                default: tgt = 32'($urandom_range(0, 255));
            endcase
            step(br, br ? tgt : 32'h0, $urandom_range(0, 3) != 0);
        end
        chk("deliveries_min", {31'b0, deliveries >= 50}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
